ui5640cfg_seq: RTL and testbench



---
 rtl/ui5640cfg_seq.sv | 137 +++++++++++++
 tb/tb_ui5640cfg_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ui5640cfg_seq.sv
// Camera register-table configuration sequencer: walks REG_SIZE table entries through an SCCB write engine.
// Optional WAIT watchdog is built only when UI5640CFG_TIMEOUT_EN is defined.
module ui5640cfg_seq #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int DELAY_INDEX = 1,
  parameter int DELAY_MS    = 5,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [8:0]  REG_INDEX,
  input  logic [31:0] REG_DATA,
  input  logic [8:0]  REG_SIZE,
  output logic        wr_req_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic        wr_busy_i,
  input  logic        wr_done_i,
  input  logic        wr_nack_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o
);

  localparam int DELAY_CYC = CLK_FREQ_HZ / 1000 * DELAY_MS;
  localparam bit HAS_DELAY = (DELAY_CYC != 0);
  localparam int DLY_W     = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int RTRY_W    = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT, DELAY, NEXT, DONE, ERR
  } state_t;

  state_t            state, state_d;
  logic [8:0]        reg_index;
  logic [RTRY_W-1:0] retry_cnt;
  logic [DLY_W-1:0]  delay_cnt;
  logic              wr_req;
  logic [15:0]       wr_addr;
  logic [7:0]        wr_data;

  logic wr_ok, wr_fail, retry_left, last_entry, at_delay_idx, delay_end;
  logic unused_reg_data;

  assign unused_reg_data = ^REG_DATA[31:24];

`ifdef UI5640CFG_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  // A silent engine counts as a NACK once WAIT has lasted TIMEOUT_CYC cycles.
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign wr_fail    = (state == WAIT) && ((wr_done_i && wr_nack_i) || (!wr_done_i && wd_expired));
`else
  assign wr_fail    = (state == WAIT) && wr_done_i && wr_nack_i;
`endif

  assign wr_ok        = (state == WAIT) && wr_done_i && !wr_nack_i;
  assign retry_left   = (retry_cnt < RTRY_W'(MAX_RETRY));
  assign last_entry   = (({1'b0, reg_index} + 10'd1) >= {1'b0, REG_SIZE});
  assign at_delay_idx = (reg_index == 9'(DELAY_INDEX));
  assign delay_end    = (delay_cnt == DLY_W'(DELAY_CYC - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start_i) state_d = (REG_SIZE == 9'd0) ? DONE : LOAD;
      end
      LOAD:  state_d = REQ;
      REQ:   if (!wr_busy_i) state_d = WAIT;
      WAIT: begin
        if (wr_ok)        state_d = (at_delay_idx && HAS_DELAY) ? DELAY : NEXT;
        else if (wr_fail) state_d = retry_left ? REQ : ERR;
      end
      DELAY: if (delay_end) state_d = NEXT;
      NEXT:  state_d = last_entry ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      reg_index <= '0;
      retry_cnt <= '0;
      delay_cnt <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_d;
      wr_req    <= (state == REQ) && !wr_busy_i;
      delay_cnt <= (state == DELAY) ? delay_cnt + 1'b1 : '0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            reg_index <= '0;
            retry_cnt <= '0;
          end
        end
        LOAD: begin
          wr_addr <= REG_DATA[23:8];
          wr_data <= REG_DATA[7:0];
        end
        WAIT: if (wr_fail && retry_left) retry_cnt <= retry_cnt + 1'b1;
        NEXT: begin
          if (!last_entry) begin
            reg_index <= reg_index + 9'd1;
            retry_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UI5640CFG_TIMEOUT_EN
  // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
  always_ff @(posedge clk_i) begin
    if (rst_i) wd_cnt <= '0;
    else       wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
  end
`endif

  assign REG_INDEX  = reg_index;
  assign wr_req_o   = wr_req;
  assign wr_addr_o  = wr_addr;
  assign wr_data_o  = wr_data;
  assign cfg_busy_o = !((state == IDLE) || (state == DONE) || (state == ERR));
  assign cfg_done_o = (state == DONE);
  assign cfg_err_o  = (state == ERR);

endmodule

// File: tb/tb_ui5640cfg_seq.sv
// Bench for ui5640cfg_seq: table-driven sequence scenarios against a scripted SCCB engine model,
// plus directed reset, delay-gap, empty-table and (with UI5640CFG_TIMEOUT_EN) watchdog sequences.
module tb_ui5640cfg_seq;

  localparam int CLK_HZ = 1000000;
  localparam int DLY    = 5000;
  localparam int TO     = 100;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [8:0]  reg_index, reg_size;
  logic [31:0] reg_data;
  logic        wr_req, wr_busy, wr_done, wr_nack;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cfg_busy, cfg_done, cfg_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] tbl(input logic [8:0] i);
    logic [15:0] a;
    logic [7:0]  v;
    a = 16'h3000 + 16'(i) * 16'd3;
    v = i[7:0] ^ 8'h5A;
    return {8'hC3, a, v};
  endfunction

  assign reg_data = tbl(reg_index);

  ui5640cfg_seq #(
    .CLK_FREQ_HZ(CLK_HZ), .DELAY_INDEX(1), .DELAY_MS(5), .MAX_RETRY(3), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .REG_INDEX(reg_index), .REG_DATA(reg_data), .REG_SIZE(reg_size),
    .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_busy_i(wr_busy), .wr_done_i(wr_done), .wr_nack_i(wr_nack),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .cfg_err_o(cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // engine model state and write log
  int cyc, writes, exp_idx, nacks_given, nack_idx, nack_cnt, order_err, nidx_reqs;
  int first_idx, last_ack_idx, busy_cnt, cur_idx, bad_idx;
  bit pend_nack, mute, force_done;
  int t_req[256];
  int t_ack[256];
  int treq_all[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    writes = 0; exp_idx = 0; nacks_given = 0; order_err = 0; nidx_reqs = 0;
    first_idx = -1; last_ack_idx = -1; bad_idx = -1;
    for (int i = 0; i < 256; i++) begin
      t_req[i] = -1;
      t_ack[i] = -1;
    end
    for (int i = 0; i < 8; i++) treq_all[i] = -1;
  endtask

  initial begin : engine
    logic [31:0] e;
    wr_busy = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    busy_cnt = 0; cyc = 0; pend_nack = 1'b0; cur_idx = 0;
    forever begin
      @(negedge clk);
      cyc++;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (rst) begin
        busy_cnt = 0;
        wr_busy  = 1'b0;
      end else begin
        if (force_done) begin
          wr_done = 1'b1; wr_nack = 1'b1; force_done = 1'b0;
        end
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            wr_busy = 1'b0;
            wr_done = 1'b1;
            wr_nack = pend_nack;
            if (!pend_nack) begin
              t_ack[cur_idx] = cyc;
              last_ack_idx   = cur_idx;
            end
          end
        end
        if (wr_req) begin
          e = tbl(9'(exp_idx));
          if (writes == 0) first_idx = int'(reg_index);
          if (writes < 8) treq_all[writes] = cyc;
          if (t_req[reg_index[7:0]] < 0) t_req[reg_index[7:0]] = cyc;
          if (int'(reg_index) != exp_idx || wr_addr != e[23:8] || wr_data != e[7:0]) begin
            order_err++;
            if (bad_idx < 0) bad_idx = int'(reg_index);
          end
          writes++;
          cur_idx = int'(reg_index);
          if (cur_idx == nack_idx) nidx_reqs++;
          if (!mute) begin
            wr_busy   = 1'b1;
            busy_cnt  = 3;
            pend_nack = (cur_idx == nack_idx) && (nacks_given < nack_cnt);
            if (pend_nack) nacks_given++;
            else exp_idx++;
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    int n;
    n = 0;
    while (!(cfg_done || cfg_err) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", int'(cfg_done || cfg_err), 1);
  endtask

  typedef struct {
    int size;
    int nack_idx;
    int nack_cnt;
    int restart_at;
    int exp_writes;
    int exp_done;
    int exp_err;
    int exp_index;
    int exp_nidx_reqs;
  } vec_t;

  task automatic run_vec(input vec_t v, input int k);
    int n;
    clear_log();
    nack_idx = v.nack_idx;
    nack_cnt = v.nack_cnt;
    reg_size = 9'(v.size);
    pulse_start();
    if (v.restart_at > 0) begin
      n = 0;
      while (writes < v.restart_at && n < 20000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d_busy_at_restart", k), int'(cfg_busy), 1);
      pulse_start();
    end
    wait_end(20000);
    repeat (20) @(negedge clk);
    if (order_err != 0) $display("FAIL v%0d_order: first bad index %0d", k, bad_idx);
    check($sformatf("v%0d_order_errors", k), order_err, 0);
    check($sformatf("v%0d_writes", k), writes, v.exp_writes);
    check($sformatf("v%0d_done", k), int'(cfg_done), v.exp_done);
    check($sformatf("v%0d_err", k), int'(cfg_err), v.exp_err);
    check($sformatf("v%0d_busy", k), int'(cfg_busy), 0);
    check($sformatf("v%0d_index", k), int'(reg_index), v.exp_index);
    check($sformatf("v%0d_nidx_reqs", k), nidx_reqs, v.exp_nidx_reqs);
  endtask

  initial begin : global_guard
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    vec_t vecs[7];
    int gap12, gap23, n;

    vecs[0] = '{251,  -1, 0,  0, 251, 1, 0, 250, 0};
    vecs[1] = '{251,   7, 2,  0, 253, 1, 0, 250, 3};
    vecs[2] = '{251,   7, 4,  0,  11, 0, 1,   7, 4};
    vecs[3] = '{251, 250, 3,  0, 254, 1, 0, 250, 4};
    vecs[4] = '{  1,   0, 0,  0,   1, 1, 0,   0, 1};
    vecs[5] = '{251,  -1, 0, 20, 251, 1, 0, 250, 0};
    vecs[6] = '{  3,   2, 4,  0,   6, 0, 1,   2, 4};

    rst = 1'b1; start = 1'b0; reg_size = 9'd0;
    mute = 1'b0; force_done = 1'b0; nack_idx = -1; nack_cnt = 0;
    clear_log();
    repeat (3) @(negedge clk);
    check("rst_index", int'(reg_index), 0);
    check("rst_req", int'(wr_req), 0);
    check("rst_addr", int'(wr_addr), 0);
    check("rst_data", int'(wr_data), 0);
    check("rst_busy", int'(cfg_busy), 0);
    check("rst_done", int'(cfg_done), 0);
    check("rst_err", int'(cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // post-write delay sits exactly between index 1 and index 2
    clear_log();
    nack_idx = -1; nack_cnt = 0; reg_size = 9'd4;
    pulse_start();
    wait_end(20000);
    gap12 = t_req[2] - t_ack[1];
    gap23 = t_req[3] - t_ack[2];
    check("gap_writes", writes, 4);
    check("gap12_at_least_delay", int'(gap12 >= DLY), 1);
    check("gap_delay_exact", gap12 - gap23, DLY);

    // reset in the middle of the delay, then restart from index 0
    clear_log();
    reg_size = 9'd251;
    pulse_start();
    n = 0;
    while (last_ack_idx != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("dly_ack1_seen", last_ack_idx, 1);
    repeat (100) @(negedge clk);
    check("dly_in_delay_busy", int'(cfg_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("dly_rst_index", int'(reg_index), 0);
    check("dly_rst_addr", int'(wr_addr), 0);
    check("dly_rst_data", int'(wr_data), 0);
    check("dly_rst_busy", int'(cfg_busy), 0);
    check("dly_rst_req", int'(wr_req), 0);
    rst = 1'b0;
    clear_log();
    pulse_start();
    n = 0;
    while (writes < 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dly_restart_first_idx", first_idx, 0);
    check("dly_restart_order", order_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // empty table finishes immediately; stray wr_done outside WAIT is ignored
    clear_log();
    reg_size = 9'd0;
    pulse_start();
    check("empty_done_next_cycle", int'(cfg_done), 1);
    check("empty_busy", int'(cfg_busy), 0);
    force_done = 1'b1;
    repeat (20) @(negedge clk);
    check("empty_no_writes", writes, 0);
    check("stray_done_keeps_done", int'(cfg_done), 1);
    check("stray_done_no_err", int'(cfg_err), 0);

`ifdef UI5640CFG_TIMEOUT_EN
    clear_log();
    mute = 1'b1;
    reg_size = 9'd251;
    pulse_start();
    wait_end(2000);
    repeat (20) @(negedge clk);
    check("wd_err", int'(cfg_err), 1);
    check("wd_writes", writes, 4);
    check("wd_spacing", treq_all[1] - treq_all[0], TO + 1);
    check("wd_spacing_last", treq_all[3] - treq_all[2], TO + 1);
    check("wd_index", int'(reg_index), 0);
    mute = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
